// File: rtl/fsk_frame_scheduler_if.sv
// Byte-in / symbol-out bus between the byte source, the frame scheduler and the FSK modulator.
// The byte source holds the master side and the scheduler holds the slave side.
interface fsk_frame_scheduler_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              ser_bit;
  logic              mod_en;
  logic              bit_strobe;
  logic              frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, ser_bit, mod_en, bit_strobe, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_bit, mod_en, bit_strobe, frame_done
  );
endinterface

// File: rtl/fsk_frame_scheduler.sv
// Frames one byte as alternating preamble, MSB-first data and a space stop bit for the FSK modulator.
// Every symbol lasts BIT_PERIOD clocks and every output is driven from a flop.
module fsk_frame_scheduler #(
  parameter int BIT_PERIOD    = 12,
  parameter int DATA_W        = 8,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  fsk_frame_scheduler_if.slave bus
);
  localparam int CYC_W   = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BIT_MAX = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_PERIOD - 1);
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    STOP     = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CYC_W-1:0]  cyc_cnt_r, cyc_cnt_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              sym_end_s;
  logic              din_ready_r, ser_bit_r, mod_en_r, bit_strobe_r, frame_done_r;
  logic              din_ready_s, ser_bit_s, mod_en_s, bit_strobe_s, frame_done_s;

  // Next state, counters and shift register; outputs are decoded from the next state so they can be registered.
  always_comb begin
    state_s   = state_r;
    cyc_cnt_s = cyc_cnt_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    sym_end_s = (cyc_cnt_r == CYC_LAST);

    if (state_r == IDLE) begin
      cyc_cnt_s = '0;
    end else if (sym_end_s) begin
      cyc_cnt_s = '0;
    end else begin
      cyc_cnt_s = cyc_cnt_r + CYC_ONE;
    end

    case (state_r)
      IDLE: begin
        if (bus.din_valid) begin
          state_s   = PREAMBLE;
          bit_cnt_s = '0;
          shift_s   = bus.din;
        end else begin
          state_s   = IDLE;
        end
      end
      PREAMBLE: begin
        if (sym_end_s && (bit_cnt_r == PRE_LAST)) begin
          state_s   = DATA;
          bit_cnt_s = '0;
        end else if (sym_end_s) begin
          bit_cnt_s = bit_cnt_r + BIT_ONE;
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      DATA: begin
        // The shift happens only on data-symbol boundaries, so the MSB is presented first.
        if (sym_end_s) begin
          shift_s = shift_r << 1;
          if (bit_cnt_r == DATA_LAST) begin
            state_s   = STOP;
            bit_cnt_s = '0;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
          end
        end else begin
          shift_s = shift_r;
        end
      end
      STOP: begin
        if (sym_end_s) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    din_ready_s  = (state_s == IDLE);
    mod_en_s     = (state_s != IDLE);
    bit_strobe_s = (state_s != IDLE) && (cyc_cnt_s == '0);
    frame_done_s = (state_r == STOP) && (state_s == IDLE);

    case (state_s)
      PREAMBLE: ser_bit_s = ~bit_cnt_s[0];
      DATA:     ser_bit_s = shift_s[DATA_W-1];
      default:  ser_bit_s = 1'b0;
    endcase
  end

  // State, counters, shift register and output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cyc_cnt_r    <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      din_ready_r  <= 1'b1;
      ser_bit_r    <= 1'b0;
      mod_en_r     <= 1'b0;
      bit_strobe_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cyc_cnt_r    <= cyc_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      shift_r      <= shift_s;
      din_ready_r  <= din_ready_s;
      ser_bit_r    <= ser_bit_s;
      mod_en_r     <= mod_en_s;
      bit_strobe_r <= bit_strobe_s;
      frame_done_r <= frame_done_s;
    end
  end

  assign bus.din_ready  = din_ready_r;
  assign bus.ser_bit    = ser_bit_r;
  assign bus.mod_en     = mod_en_r;
  assign bus.bit_strobe = bit_strobe_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_fsk_frame_scheduler.sv
// Scoreboard bench: two schedulers (default and minimal parameters) share one random stimulus stream;
// a frame-level model predicts acceptance and every output cycle, and a monitor compares each cycle.
module tb_fsk_frame_scheduler;
  localparam int DW  = 8;
  localparam int BP0 = 12;
  localparam int PB0 = 8;
  localparam int BP1 = 2;
  localparam int PB1 = 1;
  localparam int L0  = (PB0 + DW + 1) * BP0;
  localparam int L1  = (PB1 + DW + 1) * BP1;

  typedef struct {
    int          acc;
    logic [7:0]  data;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fsk_frame_scheduler_if #(.DATA_W(DW)) bus0 ();
  fsk_frame_scheduler_if #(.DATA_W(DW)) bus1 ();

  fsk_frame_scheduler #(.BIT_PERIOD(BP0), .DATA_W(DW), .PREAMBLE_BITS(PB0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fsk_frame_scheduler #(.BIT_PERIOD(BP1), .DATA_W(DW), .PREAMBLE_BITS(PB1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int          edge_cnt = 0;
  int          n_chk    = 0;
  int          n_fail   = 0;
  int          free0    = 0;
  int          free1    = 0;
  frame_t      q0[$];
  frame_t      q1[$];
  logic [63:0] cap_v [2];
  int          cap_n [2];

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %0h, expected %0h", name, id, edge_cnt, act, exp);
    end
  endtask

  // Symbol i of a frame: alternating preamble from 1, data MSB-first, then a 0 stop bit.
  function automatic logic sym(input logic [7:0] d, input int i, input int pb);
    if (i < pb) return (i % 2 == 0);
    else if (i < pb + DW) return d[DW - 1 - (i - pb)];
    else return 1'b0;
  endfunction

  function automatic logic [63:0] frame_bits(input logic [7:0] d, input int pb);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < pb + DW + 1; i++) v = {v[62:0], sym(d, i, pb)};
    return v;
  endfunction

  // Expected {din_ready, mod_en, bit_strobe, ser_bit, frame_done} for the cycle after edge e.
  function automatic logic [4:0] exp_outs(input bit has, input frame_t h, input int e, input int bp, input int pb);
    int k;
    int len;
    len = (pb + DW + 1) * bp;
    k   = e - h.acc;
    if (has && k >= 0 && k < len) return {1'b0, 1'b1, 1'(k % bp == 0), sym(h.data, k / bp, pb), 1'b0};
    if (has && k == len) return 5'b10001;
    return 5'b10000;
  endfunction

  task automatic mon_dut(input int id, input logic [4:0] act, input bit has, input frame_t h,
                         input int bp, input int pb, output bit pop);
    logic [4:0] exp;
    pop = 1'b0;
    exp = exp_outs(has, h, edge_cnt, bp, pb);
    check("outs", id, 64'(act), 64'(exp));
    if (act[2] === 1'b1) begin
      cap_v[id] = {cap_v[id][62:0], act[1]};
      cap_n[id]++;
    end
    if (act[0] === 1'b1) begin
      pop = 1'b1;
      check("sym_count", id, 64'(cap_n[id]), 64'(pb + DW + 1));
      check("frame_bits", id, cap_v[id], frame_bits(h.data, pb));
    end
    if (act[3] !== 1'b1) begin
      cap_v[id] = '0;
      cap_n[id] = 0;
    end
  endtask

  always @(negedge clk) begin : monitor
    frame_t     h;
    bit         has;
    bit         p;
    logic [4:0] a;
    if (edge_cnt >= 1) begin
      a   = {bus0.din_ready, bus0.mod_en, bus0.bit_strobe, bus0.ser_bit, bus0.frame_done};
      has = (q0.size() > 0);
      h   = '{0, 8'h00};
      if (has) h = q0[0];
      mon_dut(0, a, has, h, BP0, PB0, p);
      if (p && has) void'(q0.pop_front());

      a   = {bus1.din_ready, bus1.mod_en, bus1.bit_strobe, bus1.ser_bit, bus1.frame_done};
      has = (q1.size() > 0);
      h   = '{0, 8'h00};
      if (has) h = q1[0];
      mon_dut(1, a, has, h, BP1, PB1, p);
      if (p && has) void'(q1.pop_front());
    end
  end

  // Drive one cycle of inputs, then update the acceptance model for the edge that samples them.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bus0.din_valid = v;
    bus1.din_valid = v;
    bus0.din       = d;
    bus1.din       = d;
    rst            = r;
    @(posedge clk);
    edge_cnt++;
    if (r) begin
      q0.delete();
      q1.delete();
      free0 = edge_cnt + 1;
      free1 = edge_cnt + 1;
    end else if (v) begin
      if (edge_cnt >= free0) begin
        q0.push_back('{edge_cnt, d});
        free0 = edge_cnt + L0 + 1;
      end
      if (edge_cnt >= free1) begin
        q1.push_back('{edge_cnt, d});
        free1 = edge_cnt + L1 + 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    cap_v[0] = '0;
    cap_v[1] = '0;
    cap_n[0] = 0;
    cap_n[1] = 0;

    // Reset held with valid data offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1);

    step(1'b1, 8'hA5, 1'b0);
    idle(210);

    // Back-to-back frames with valid held high.
    for (int i = 0; i < 100; i++) step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 320; i++) step(1'b1, 8'h00, 1'b0);
    idle(210);

    // Input changes mid-frame must not disturb the byte in flight.
    step(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 120; i++) step(1'b1, 8'hC3, 1'b0);
    idle(210);

    // Reset during data bit 3, then a fresh frame.
    step(1'b1, 8'h55, 1'b0);
    idle(131);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h81, 1'b0);
    idle(210);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 299) == 0));
    end
    idle(250);

    check("q_drained", 0, 64'(q0.size()), 64'd0);
    check("q_drained", 1, 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
